// File: rtl/conv_parity_encoder_pkg.sv
// Shared constants and parity helper for the rate-1/2 convolutional encoder.
package conv_enc_pkg;

  // Data word width; the codeword carries two parity bits per data bit.
  localparam int N      = 48;
  localparam int CODE_W = 2 * N;

  // Bit counter must be able to hold the value N itself.
  localparam int CNT_W  = $clog2(N + 1);

  // Generator taps ordered {current bit, s1, s2}.
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  // One parity bit: XOR of the window bits selected by the generator taps.
  function automatic logic conv_parity(input logic [2:0] win, input logic [2:0] gen);
    return ^(win & gen);
  endfunction

endpackage

// File: rtl/conv_parity_encoder_if.sv
// Load/observe bundle between the transmit controller and the encoder.
interface conv_parity_encoder_if;

  logic                              start;
  logic [conv_enc_pkg::N-1:0]        din;
  logic                              serial_bit;
  logic [conv_enc_pkg::CODE_W-1:0]   code;
  logic                              done;

  // Controller side: drives the load request and word, watches the results.
  modport master (
    output start,
    output din,
    input  serial_bit,
    input  code,
    input  done
  );

  // Encoder side.
  modport slave (
    input  start,
    input  din,
    output serial_bit,
    output code,
    output done
  );

endinterface

// File: rtl/conv_parity_encoder_piso_serializer.sv
// Parallel-in/serial-out shifter: loads a word on start and presents it MSB first.
module piso_serializer
  import conv_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_shift,
  input  logic [N-1:0] i_din,
  output logic         o_bit
);

  logic [N-1:0] r_shift;

  // Shift register: reset clears, start reloads, otherwise shift left with zero fill when asked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (i_start) begin
      r_shift <= i_din;
    end else if (i_shift) begin
      r_shift <= {r_shift[N-2:0], 1'b0};
    end else begin
      r_shift <= r_shift;
    end
  end

  // Bit about to be consumed is always the current MSB.
  assign o_bit = r_shift[N-1];

endmodule

// File: rtl/conv_parity_encoder.sv
// Rate-1/2, K=3 convolutional encoder: serializes a word MSB first and
// accumulates the two parity bits of every data bit into a 2N-bit codeword.
module conv_parity_encoder
  import conv_enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  conv_parity_encoder_if.slave  bus
);

  // Two implicit states: running through the word, or holding a finished codeword.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  logic [0:0]        r_state;
  logic [1:0]        r_enc_st;      // {s1, s2}
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_code;
  logic              r_serial_bit;

  logic              w_bit;
  logic              w_run;
  logic              w_last;
  logic [2:0]        w_win;
  logic              w_c0;
  logic              w_c1;

  // A bit is consumed on every edge that is neither a load nor in hold.
  assign w_run  = (r_state == ST_RUN) && !bus.start;
  assign w_last = (r_cnt == LAST_CNT);
  assign w_win  = {w_bit, r_enc_st};
  assign w_c0   = conv_parity(w_win, G0);
  assign w_c1   = conv_parity(w_win, G1);

  piso_serializer u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (bus.start),
    .i_shift (w_run),
    .i_din   (bus.din),
    .o_bit   (w_bit)
  );

  // Encoder state, counter, codeword accumulator and completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_enc_st     <= 2'b00;
      r_cnt        <= '0;
      r_code       <= '0;
      r_serial_bit <= 1'b0;
    end else if (bus.start) begin
      // Load (or abort and reload): nothing of a previous word survives.
      r_state      <= ST_RUN;
      r_enc_st     <= 2'b00;
      r_cnt        <= '0;
      r_code       <= '0;
      r_serial_bit <= 1'b0;
    end else if (w_run) begin
      r_enc_st     <= {w_bit, r_enc_st[1]};
      r_cnt        <= r_cnt + CNT_W'(1);
      r_code       <= {r_code[CODE_W-3:0], w_c0, w_c1};
      r_serial_bit <= w_bit;
      if (w_last) begin
        r_state <= ST_HOLD;
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      // Hold: finished codeword stays put until the next load or reset.
      r_state      <= r_state;
      r_enc_st     <= r_enc_st;
      r_cnt        <= r_cnt;
      r_code       <= r_code;
      r_serial_bit <= r_serial_bit;
    end
  end

  assign bus.code       = r_code;
  assign bus.serial_bit = r_serial_bit;
  assign bus.done       = (r_state == ST_HOLD);

endmodule

// File: tb/tb_conv_parity_encoder.sv
// Self-checking bench for conv_parity_encoder using an expected-codeword queue.
module tb_conv_parity_encoder;
  import conv_enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  conv_parity_encoder_if bus_if ();

  conv_parity_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [CODE_W-1:0] sb_q[$];

  localparam logic [CODE_W-1:0] IMP_CODE  = 96'hEC00_0000_0000_0000_0000_0000;
  localparam logic [CODE_W-1:0] ONES_CODE = 96'hDAAA_AAAA_AAAA_AAAA_AAAA_AAAA;

  task automatic check_val(input string tag, input logic [CODE_W-1:0] got,
                           input logic [CODE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference 7/5 encoder, zero start state, MSB first.
  function automatic logic [CODE_W-1:0] ref_encode(input logic [N-1:0] d);
    logic [CODE_W-1:0] c;
    logic s1, s2, b;
    c  = '0;
    s1 = 1'b0;
    s2 = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      b  = d[i];
      c  = {c[CODE_W-3:0], b ^ s1 ^ s2, b ^ s2};
      s2 = s1;
      s1 = b;
    end
    return c;
  endfunction

  task automatic load_word(input logic [N-1:0] d);
    bus_if.start = 1'b1;
    bus_if.din   = d;
    tick();
    check_val("load_done", CODE_W'(bus_if.done), '0);
    check_val("load_code", bus_if.code, '0);
    sb_q.push_back(ref_encode(d));
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic first_bit);
    int lat;
    bit seen;
    logic [CODE_W-1:0] exp;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      lat++;
      if (i == 0) check_val({tag, "_sbit0"}, CODE_W'(bus_if.serial_bit), CODE_W'(first_bit));
      if (bus_if.done) seen = 1'b1;
    end
    check_val({tag, "_latency"}, CODE_W'(lat), CODE_W'(N));
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got empty queue expected an entry", tag);
    end else begin
      exp = sb_q.pop_front();
      check_val({tag, "_code"}, bus_if.code, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.din   = '0;
    tick();
    tick();
    check_val("rst_code", bus_if.code, '0);
    check_val("rst_done", CODE_W'(bus_if.done), '0);
    check_val("rst_sbit", CODE_W'(bus_if.serial_bit), '0);
    rst_n = 1'b1;

    load_word(48'h0);
    wait_done("zero", 1'b0);
    check_val("zero_const", bus_if.code, '0);

    load_word(48'h8000_0000_0000);
    wait_done("imp", 1'b1);
    check_val("imp_const", bus_if.code, IMP_CODE);

    load_word(48'h0000_0000_0001);
    wait_done("lsb", 1'b0);
    check_val("lsb_const", bus_if.code, 96'h3);

    load_word(48'hFFFF_FFFF_FFFF);
    wait_done("ones", 1'b1);
    check_val("ones_const", bus_if.code, ONES_CODE);
    repeat (20) tick();
    check_val("hold_code", bus_if.code, ONES_CODE);
    check_val("hold_done", CODE_W'(bus_if.done), 96'h1);

    load_word(48'h03_01_02_03_30_3A);
    wait_done("mixed", 1'b0);
    load_word(48'h8000_0000_0000);
    wait_done("reload_imp", 1'b1);
    check_val("reload_const", bus_if.code, IMP_CODE);

    // Reset in the middle of an encode.
    load_word(48'hFFFF_FFFF_FFFF);
    void'(sb_q.pop_back());
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_code", bus_if.code, '0);
    check_val("mid_rst_done", CODE_W'(bus_if.done), '0);
    check_val("mid_rst_sbit", CODE_W'(bus_if.serial_bit), '0);
    rst_n = 1'b1;
    sb_q.push_back('0);
    wait_done("post_rst", 1'b0);

    load_word(48'h1234_5678_9ABC);
    wait_done("after_rst", 1'b0);

    // Reset and start on the same edge: reset must win.
    bus_if.start = 1'b1;
    bus_if.din   = 48'h8000_0000_0000;
    rst_n        = 1'b0;
    tick();
    check_val("both_code", bus_if.code, '0);
    check_val("both_done", CODE_W'(bus_if.done), '0);
    rst_n        = 1'b1;
    bus_if.start = 1'b0;
    sb_q.push_back('0);
    wait_done("rst_wins", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_parity_encoder.md
Name: conv_parity_encoder

Overview:
- Rate-1/2 convolutional (parity) encoder front end for the digital-communication transmit chain.
- Loads an N-bit parallel word and serializes it MSB first.
- Encodes each serial bit into two parity bits (constraint length 3, generators 7/5 octal) and accumulates the 2N-bit codeword.
- Asserts done when the full codeword is valid. Downstream modulator/channel blocks consume the codeword.

Parameters:
- N, 48, data word width; codeword width is 2*N.
- G0, 3'b111, generator polynomial for first parity bit.
- G1, 3'b101, generator polynomial for second parity bit.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  active-high load/restart, sampled on rising edge.
- din  input  N  parallel data word, sampled only when start=1.
- serial_bit  output  1  current serializer output bit (debug/observe).
- code  output  2N  accumulated codeword.
- done  output  1  codeword complete flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - shift register, encoder state {s1,s2}, bit counter, code, serial_bit and done all cleared to 0.
  - Reset has priority over start.
- Load (start=1 at posedge, rst_n=1):
  - shift register <= din; encoder state <= 00; counter <= 0; code <= 0; done <= 0.
  - No bit is encoded on a load edge.
  - start held high keeps reloading.
- Run (start=0, done=0):
  - Each posedge consumes one bit b = shift register MSB (din[N-1] first), then shifts left with 0 fill.
  - c0 = b^s1^s2 (G0), c1 = b^s2 (G1).
  - code <= {code[2N-3:0], c0, c1}.
  - s2 <= s1, s1 <= b, counter++.
  - serial_bit presents the bit being consumed, registered.
- Completion:
  - On the posedge consuming the N-th bit, done <= 1 in the same edge as the final code update.
  - Latency is exactly N clocks after the first start=0 edge.
  - First pair ends at code[2N-1:2N-2]; last pair at code[1:0].
- Hold:
  - While done=1, code, state and counter are frozen and done stays 1 until the next start or reset.
  - Extra clocks are ignored.
- No tail/flush bits are appended; the encoder is not terminated.
- start asserted mid-encode aborts and reloads with no partial output retained.
- rst_n low mid-encode clears everything per the Reset rule.
- Counter width is ceil(log2(N+1)).
- No combinational path from din to any output.

Decomposition:
- Package conv_enc_pkg holds N, G0, G1 and CODE_W = 2*N.
- One natural sub-module, piso_serializer (parallel-in/serial-out, load on start, MSB first). It takes clk, rst_n, start and din, and outputs the bit.
- The encoder FSM, parity logic and codeword accumulator live in the top.
- Two implicit states: IDLE/DONE (hold) and RUN (counter < N).

Test Plan:
- Reset, then start for 1 cycle with din=48'h0, run 60 clocks -> code=96'h0, done rises exactly 48 clocks after start falls.
- din=48'h800000000000 -> code=96'hEC00_0000_0000_0000_0000_0000 (impulse response 11 10 11), done=1.
- din=48'h000000000001 -> code=96'h0000_0000_0000_0000_0000_0003, done=1.
- din=48'hFFFFFFFFFFFF -> code=96'hDAAA_AAAA_AAAA_AAAA_AAAA_AAAA. Then hold 20 extra clocks -> code and done unchanged.
- din=48'h03_01_02_03_30_3A encoded to completion -> compare against a reference model of the 7/5 encoder. Then pulse start with din=48'h800000000000 -> done drops next edge, code cleared, final code=96'hEC00_...0.
- Mid-encode at bit 20:
  - drive rst_n=0 for 1 clock -> code=0, done=0, serializer cleared;
  - a subsequent start/run completes normally;
  - start and rst_n both low-active on the same edge -> reset wins.
